// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 exception definitions: cause codes, CP0 register addresses and
// field positions, and the fixed cause-priority selector.
package exc_ctrl_pkg;

    localparam int EXC_TYPE_BUS = 4;

    typedef enum logic [EXC_TYPE_BUS-1:0] {
        EXC_NONE = 4'd0,
        EXC_INT  = 4'd1,
        EXC_IF   = 4'd2,
        EXC_ADEL = 4'd3,
        EXC_RI   = 4'd4,
        EXC_OV   = 4'd5,
        EXC_BP   = 4'd6,
        EXC_SYS  = 4'd7,
        EXC_ADES = 4'd8,
        EXC_ERET = 4'd9
    } exc_type_e;

    localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 9;

    // Software-writable fields; everything else keeps the CP0 value.
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic exc_type_e pick_exc(
        input logic irq, input logic f_if, input logic f_ri, input logic f_ov,
        input logic f_bp, input logic f_sys, input logic f_adel,
        input logic f_ades, input logic f_eret
    );
        if (irq)         return EXC_INT;
        else if (f_if)   return EXC_IF;
        else if (f_ri)   return EXC_RI;
        else if (f_ov)   return EXC_OV;
        else if (f_bp)   return EXC_BP;
        else if (f_sys)  return EXC_SYS;
        else if (f_adel) return EXC_ADEL;
        else if (f_ades) return EXC_ADES;
        else if (f_eret) return EXC_ERET;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// N-stage flop synchroniser for the external interrupt lines.
module int_sync #(
    parameter int N = 2,
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [N-1:0][W-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            sr <= {sr[N-2:0], d};
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception arbitration between MEM and CP0: picks the highest-priority cause
// and issues a one-cycle registered event, flush and redirect PC.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  interrupt_i,
    input  logic        mem_valid,
    input  logic        stall_i,
    input  logic [31:0] mem_pc,
    input  logic        mem_delayslot,
    input  logic        mem_exc_if,
    input  logic        mem_exc_ri,
    input  logic        mem_exc_ov,
    input  logic        mem_exc_bp,
    input  logic        mem_exc_sys,
    input  logic        mem_exc_adel,
    input  logic        mem_exc_ades,
    input  logic        mem_eret,
    input  logic [31:0] mem_badvaddr,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_write_en,
    input  logic [4:0]  cp0_write_addr,
    input  logic [31:0] cp0_write_data,
    output logic [3:0]  exception_type,
    output logic        delayslot_flag,
    output logic [31:0] current_pc_addr,
    output logic [31:0] badvaddr_o,
    output logic [5:0]  interrupt_o,
    output logic        flush_o,
    output logic [31:0] exc_pc_o
);

    int_sync #(.N(SYNC_STAGES), .W(6)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (interrupt_i),
        .q   (interrupt_o)
    );

    // CP0 view including a write landing in the same cycle.
    logic [31:0] eff_status, eff_cause, eff_epc;

    always_comb begin
        eff_status = cp0_status;
        eff_cause  = cp0_cause;
        eff_epc    = cp0_epc;
        if (cp0_write_en) begin
            case (cp0_write_addr)
                CP0_ADDR_STATUS: eff_status = (cp0_status & ~STATUS_WMASK) | (cp0_write_data & STATUS_WMASK);
                CP0_ADDR_CAUSE:  eff_cause  = (cp0_cause  & ~CAUSE_WMASK)  | (cp0_write_data & CAUSE_WMASK);
                CP0_ADDR_EPC:    eff_epc    = cp0_write_data;
                default: ;
            endcase
        end
    end

    logic      int_pending;
    exc_type_e cand;

    assign int_pending = eff_status[STATUS_IE] && !eff_status[STATUS_EXL] &&
        |(eff_status[STATUS_IM_HI:STATUS_IM_LO] & {interrupt_o, eff_cause[CAUSE_IP_HI:CAUSE_IP_LO]});

    assign cand = pick_exc(int_pending, mem_exc_if, mem_exc_ri, mem_exc_ov, mem_exc_bp,
                           mem_exc_sys, mem_exc_adel, mem_exc_ades, mem_eret);

    logic unused_bits;
    assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:10], eff_cause[7:0]};

    state_e      state, state_n;
    exc_type_e   type_n;
    logic        dly_n, flush_n;
    logic [31:0] pc_n, bad_n, excpc_n;

    always_comb begin
        state_n = state;
        type_n  = EXC_NONE;
        flush_n = 1'b0;
        dly_n   = delayslot_flag;
        pc_n    = current_pc_addr;
        bad_n   = badvaddr_o;
        excpc_n = exc_pc_o;
        case (state)
            ST_IDLE: begin
                if (mem_valid && !stall_i && cand != EXC_NONE) begin
                    state_n = ST_FLUSH;
                    type_n  = cand;
                    flush_n = 1'b1;
                    dly_n   = mem_delayslot;
                    pc_n    = mem_pc;
                    if (cand == EXC_IF)
                        bad_n = mem_pc;
                    else if (cand == EXC_ADEL || cand == EXC_ADES)
                        bad_n = mem_badvaddr;
                    excpc_n = (cand == EXC_ERET) ? eff_epc : EXC_VECTOR;
                end
            end
            // The MEM instruction seen here is wrong-path; it is dropped.
            ST_FLUSH: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            exception_type  <= EXC_NONE;
            flush_o         <= 1'b0;
            delayslot_flag  <= 1'b0;
            current_pc_addr <= '0;
            badvaddr_o      <= '0;
            exc_pc_o        <= '0;
        end else begin
            state           <= state_n;
            exception_type  <= type_n;
            flush_o         <= flush_n;
            delayslot_flag  <= dly_n;
            current_pc_addr <= pc_n;
            badvaddr_o      <= bad_n;
            exc_pc_o        <= excpc_n;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam int          SYNC = 2;

    logic        clk, rst;
    logic [5:0]  interrupt_i;
    logic        mem_valid, stall_i, mem_delayslot;
    logic [31:0] mem_pc, mem_badvaddr;
    logic        mem_exc_if, mem_exc_ri, mem_exc_ov, mem_exc_bp, mem_exc_sys;
    logic        mem_exc_adel, mem_exc_ades, mem_eret;
    logic [31:0] cp0_status, cp0_cause, cp0_epc, cp0_write_data;
    logic        cp0_write_en;
    logic [4:0]  cp0_write_addr;
    logic [3:0]  exception_type;
    logic        delayslot_flag, flush_o;
    logic [31:0] current_pc_addr, badvaddr_o, exc_pc_o;
    logic [5:0]  interrupt_o;

    exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .interrupt_i(interrupt_i),
        .mem_valid(mem_valid), .stall_i(stall_i), .mem_pc(mem_pc),
        .mem_delayslot(mem_delayslot), .mem_exc_if(mem_exc_if),
        .mem_exc_ri(mem_exc_ri), .mem_exc_ov(mem_exc_ov), .mem_exc_bp(mem_exc_bp),
        .mem_exc_sys(mem_exc_sys), .mem_exc_adel(mem_exc_adel),
        .mem_exc_ades(mem_exc_ades), .mem_eret(mem_eret),
        .mem_badvaddr(mem_badvaddr), .cp0_status(cp0_status),
        .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .cp0_write_en(cp0_write_en),
        .cp0_write_addr(cp0_write_addr), .cp0_write_data(cp0_write_data),
        .exception_type(exception_type), .delayslot_flag(delayslot_flag),
        .current_pc_addr(current_pc_addr), .badvaddr_o(badvaddr_o),
        .interrupt_o(interrupt_o), .flush_o(flush_o), .exc_pc_o(exc_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the outputs should read after each edge.
    bit          m_busy;
    bit [3:0]    m_type;
    bit          m_flush, m_dly;
    bit [31:0]   m_pc, m_bad, m_epc;
    bit [5:0]    m_sync[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_type = 0; m_flush = 0; m_dly = 0;
        m_pc = 0; m_bad = 0; m_epc = 0;
        m_sync.delete();
        for (int i = 0; i < SYNC; i++) m_sync.push_back(6'd0);
    endtask

    task automatic clear_inputs();
        mem_valid = 0; stall_i = 0; mem_delayslot = 0; mem_pc = 0; mem_badvaddr = 0;
        mem_exc_if = 0; mem_exc_ri = 0; mem_exc_ov = 0; mem_exc_bp = 0;
        mem_exc_sys = 0; mem_exc_adel = 0; mem_exc_ades = 0; mem_eret = 0;
        cp0_write_en = 0; cp0_write_addr = 0; cp0_write_data = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".type"},  {28'd0, exception_type}, {28'd0, m_type});
        check({tag, ".flush"}, {31'd0, flush_o},        {31'd0, m_flush});
        check({tag, ".dly"},   {31'd0, delayslot_flag}, {31'd0, m_dly});
        check({tag, ".pc"},    current_pc_addr,         m_pc);
        check({tag, ".bad"},   badvaddr_o,              m_bad);
        check({tag, ".epc"},   exc_pc_o,                m_epc);
        check({tag, ".irq"},   {26'd0, interrupt_o},    {26'd0, m_sync[0]});
    endtask

    // Predict the result of the coming edge from the present inputs, clock, compare.
    task automatic tick(input string tag);
        bit [31:0] st, ca, ep;
        bit        ipend;
        bit [8:0]  flags;
        int        codes[9] = '{1, 2, 4, 5, 6, 7, 3, 8, 9};
        st = cp0_status; ca = cp0_cause; ep = cp0_epc;
        if (cp0_write_en) begin
            if (cp0_write_addr == 5'd12) begin
                st[22] = cp0_write_data[22];
                st[15:8] = cp0_write_data[15:8];
                st[1:0] = cp0_write_data[1:0];
            end else if (cp0_write_addr == 5'd13) begin
                ca[9:8] = cp0_write_data[9:8];
            end else if (cp0_write_addr == 5'd14) begin
                ep = cp0_write_data;
            end
        end
        ipend = st[0] && !st[1] && ((st[15:8] & {m_sync[0], ca[9:8]}) != 8'd0);
        flags = {mem_eret, mem_exc_ades, mem_exc_adel, mem_exc_sys, mem_exc_bp,
                 mem_exc_ov, mem_exc_ri, mem_exc_if, ipend};
        m_type = 0;
        m_flush = 0;
        if (m_busy) begin
            m_busy = 0;
        end else if (mem_valid && !stall_i) begin
            for (int i = 0; i < 9; i++) begin
                if (flags[i]) begin
                    m_type = codes[i][3:0];
                    m_flush = 1;
                    m_busy = 1;
                    m_dly = mem_delayslot;
                    m_pc = mem_pc;
                    if (codes[i] == 2) m_bad = mem_pc;
                    if (codes[i] == 3 || codes[i] == 8) m_bad = mem_badvaddr;
                    m_epc = (codes[i] == 9) ? ep : VEC;
                    break;
                end
            end
        end
        m_sync.push_back(interrupt_i);
        void'(m_sync.pop_front());
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 0;
        interrupt_i = 0;
        cp0_status = 0; cp0_cause = 0; cp0_epc = 0;
        clear_inputs();
        model_reset();
        #12;
        check_all("reset");
        rst = 1;

        // SYS, then its single-cycle pulse ends
        mem_valid = 1; mem_exc_sys = 1; mem_pc = 32'h8000_0100;
        tick("sys");
        check("sys.const_type", {28'd0, exception_type}, 32'd7);
        check("sys.const_vec", exc_pc_o, 32'hBFC0_0380);
        clear_inputs();
        tick("sys_end");
        check("sys_end.const_flush", {31'd0, flush_o}, 32'd0);

        // RI beats OV; delay slot recorded
        mem_valid = 1; mem_exc_ri = 1; mem_exc_ov = 1; mem_delayslot = 1; mem_pc = 32'h8000_0104;
        tick("ri_ov");
        check("ri_ov.const_type", {28'd0, exception_type}, 32'd4);
        tick("ri_ov_flush");
        clear_inputs();
        tick("ri_ov_idle");

        // ADES captures data address, IF captures fetch PC
        mem_valid = 1; mem_exc_ades = 1; mem_badvaddr = 32'h8000_0003; mem_pc = 32'h8000_0108;
        tick("ades");
        check("ades.const_bad", badvaddr_o, 32'h8000_0003);
        clear_inputs();
        tick("ades_end");
        mem_valid = 1; mem_exc_if = 1; mem_pc = 32'h8000_0002;
        tick("if");
        check("if.const_type", {28'd0, exception_type}, 32'd2);
        check("if.const_bad", badvaddr_o, 32'h8000_0002);
        clear_inputs();
        tick("if_end");

        // Interrupt through the synchroniser, then masked by a same-cycle Status write
        cp0_status = 32'h0000_0401;
        interrupt_i = 6'b000001;
        for (int i = 0; i < SYNC; i++) tick("irq_sync");
        check("irq_sync.const", {26'd0, interrupt_o}, 32'd1);
        mem_valid = 1; mem_pc = 32'h8000_0110;
        tick("irq_take");
        check("irq_take.const_type", {28'd0, exception_type}, 32'd1);
        clear_inputs();
        tick("irq_end");
        mem_valid = 1; mem_pc = 32'h8000_0114;
        cp0_write_en = 1; cp0_write_addr = 5'd12; cp0_write_data = 32'h0;
        tick("irq_masked");
        check("irq_masked.const_flush", {31'd0, flush_o}, 32'd0);
        clear_inputs();
        interrupt_i = 0;
        cp0_status = 0;
        for (int i = 0; i < SYNC; i++) tick("irq_drop");

        // ERET redirects to the forwarded EPC
        mem_valid = 1; mem_eret = 1; cp0_epc = 32'h8000_0200; mem_pc = 32'h8000_0120;
        cp0_write_en = 1; cp0_write_addr = 5'd14; cp0_write_data = 32'h8000_0300;
        tick("eret");
        check("eret.const_epc", exc_pc_o, 32'h8000_0300);
        clear_inputs();
        tick("eret_end");

        // BP held off by stall, taken on first free cycle
        mem_valid = 1; mem_exc_bp = 1; stall_i = 1; mem_pc = 32'h8000_0130;
        for (int i = 0; i < 3; i++) tick("bp_stall");
        stall_i = 0;
        tick("bp_go");
        check("bp_go.const_type", {28'd0, exception_type}, 32'd6);

        // Reset while in FLUSH clears outputs immediately
        #2 rst = 0;
        #1;
        model_reset();
        check_all("rst_flush");
        #2 rst = 1;
        clear_inputs();
        tick("post_rst_idle");
        mem_valid = 1; mem_exc_sys = 1; mem_pc = 32'h8000_0140;
        tick("post_rst_hit");
        clear_inputs();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            mem_valid     = ($urandom_range(0, 3) != 0);
            stall_i       = ($urandom_range(0, 5) == 0);
            mem_delayslot = $urandom_range(0, 1) != 0;
            mem_pc        = $urandom;
            mem_badvaddr  = $urandom;
            mem_exc_if    = ($urandom_range(0, 15) == 0);
            mem_exc_ri    = ($urandom_range(0, 15) == 0);
            mem_exc_ov    = ($urandom_range(0, 15) == 0);
            mem_exc_bp    = ($urandom_range(0, 15) == 0);
            mem_exc_sys   = ($urandom_range(0, 15) == 0);
            mem_exc_adel  = ($urandom_range(0, 15) == 0);
            mem_exc_ades  = ($urandom_range(0, 15) == 0);
            mem_eret      = ($urandom_range(0, 15) == 0);
            cp0_status    = $urandom;
            cp0_cause     = $urandom;
            cp0_epc       = $urandom;
            cp0_write_en  = ($urandom_range(0, 3) == 0);
            cp0_write_addr = 5'($urandom_range(11, 14));
            cp0_write_data = $urandom;
            if ($urandom_range(0, 9) == 0) interrupt_i = 6'($urandom);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
